// File: rtl/sha256_generator.sv
// SHA-256 compression-round engine: one round per clock, internal message schedule, freeze after round 63.
// Optional macro SHA256_CSA_OUT_EN keeps the new A word in carry-save form (a_sum, a_carry).

package sha256_generator_pkg;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

module sha256_generator
    import sha256_generator_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   round,
    input  logic [31:0]  word_in,
    input  logic [255:0] hash_in,
    output logic         ready,
    output logic [287:0] state_out
);

    logic [31:0] a_sum_q, a_sum_d;
    logic [31:0] a_carry_q, a_carry_d;
    logic [31:0] b_q, b_d, c_q, c_d, d_q, d_d;
    logic [31:0] e_q, e_d, f_q, f_d, g_q, g_d, h_q, h_d;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic        ready_q, ready_d;

    logic [31:0] a_reg;
    logic [31:0] a_in, b_in, c_in, d_in, e_in, f_in, g_in, h_in;
    logic [31:0] w_t, t1, sig0_a, maj_abc, ch_efg;
    logic        execute;

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block can infer a latch.
        a_sum_d   = a_sum_q;
        a_carry_d = a_carry_q;
        b_d = b_q; c_d = c_q; d_d = d_q;
        e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
        w_d       = w_q;
        ready_d   = ready_q;

        a_reg   = a_sum_q + a_carry_q;
        execute = (round == 6'd0) || !ready_q;

        if (round == 6'd0) begin
            {a_in, b_in, c_in, d_in, e_in, f_in, g_in, h_in} = hash_in;
        end else begin
            {a_in, b_in, c_in, d_in, e_in, f_in, g_in, h_in} =
                {a_reg, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
        end

        // Window slot 15 holds W[t-1], slot 0 holds W[t-16].
        if (round < 6'd16) begin
            w_t = word_in;
        end else begin
            w_t = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
        end

        ch_efg  = (e_in & f_in) ^ (~e_in & g_in);
        maj_abc = (a_in & b_in) ^ (a_in & c_in) ^ (b_in & c_in);
        sig0_a  = big_sigma0(a_in);
        t1      = h_in + big_sigma1(e_in) + ch_efg + K_ROM[round] + w_t;

        if (execute) begin
`ifdef SHA256_CSA_OUT_EN
            // 3:2 compression of T1, Sigma0 and Maj; the carry-propagate add is deferred to a_reg.
            a_sum_d   = t1 ^ sig0_a ^ maj_abc;
            a_carry_d = ((t1 & sig0_a) | (t1 & maj_abc) | (sig0_a & maj_abc)) << 1;
`else
            a_sum_d   = t1 + sig0_a + maj_abc;
            a_carry_d = '0;
`endif
            b_d = a_in;
            c_d = b_in;
            d_d = c_in;
            e_d = d_in + t1;
            f_d = e_in;
            g_d = f_in;
            h_d = g_in;
            for (int i = 0; i < 15; i++) begin
                w_d[i] = w_q[i + 1];
            end
            w_d[15] = w_t;
            ready_d = (round == 6'd63);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sum_q   <= '0;
            a_carry_q <= '0;
            b_q <= '0; c_q <= '0; d_q <= '0;
            e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
            // NOTE: the W window is a flop array, not a RAM, so it can and must be cleared; a run
            // started at a non-zero round after reset would otherwise read stale schedule words.
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            ready_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            a_sum_q   <= a_sum_d;
            a_carry_q <= a_carry_d;
            b_q <= b_d; c_q <= c_d; d_q <= d_d;
            e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
            w_q       <= w_d;
            ready_q   <= ready_d;
        end
    end

    assign ready     = ready_q;
    assign state_out = {a_sum_q, a_carry_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};

endmodule

// File: tb/tb_sha256_generator.sv
// Self-checking bench for sha256_generator: FIPS "abc" vector, freeze/restart/reset behaviour,
// and random messages and round orders checked against a behavioural round model.

module tb_sha256_generator;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   round;
    logic [31:0]  word_in;
    logic [255:0] hash_in;
    logic         ready;
    logic [287:0] state_out;

    int errors = 0;
    int checks = 0;

    sha256_generator dut (
        .clk       (clk),
        .rst       (rst),
        .round     (round),
        .word_in   (word_in),
        .hash_in   (hash_in),
        .ready     (ready),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_FINAL = {
        32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
        32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894
    };

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Reference model: working variables, history of every W used (oldest first), ready flag.
    logic [31:0] m_st [8];
    logic [31:0] m_hist [$];
    bit          m_ready;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] xx;
        xx = {x, x} >> n;
        return xx[31:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_st[i] = '0;
        m_hist = {};
        repeat (16) m_hist.push_back(32'h0);
        m_ready = 0;
    endtask

    function automatic logic [31:0] w_back(input int k);
        return m_hist[16 - k];
    endfunction

    task automatic model_step(input int t, input logic [31:0] w, input logic [255:0] h);
        logic [31:0] v [8];
        logic [31:0] wt, s0, s1, t1, t2;
        if (m_ready && t != 0) return;
        for (int i = 0; i < 8; i++) v[i] = (t == 0) ? h[255 - 32*i -: 32] : m_st[i];
        if (t < 16) begin
            wt = w;
        end else begin
            s0 = ror(w_back(15), 7) ^ ror(w_back(15), 18) ^ (w_back(15) >> 3);
            s1 = ror(w_back(2), 17) ^ ror(w_back(2), 19) ^ (w_back(2) >> 10);
            wt = s1 + w_back(7) + s0 + w_back(16);
        end
        m_hist.push_back(wt);
        void'(m_hist.pop_front());
        t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
             + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[t] + wt;
        t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
             + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        for (int i = 7; i > 0; i--) m_st[i] = v[i - 1];
        m_st[4] = v[3] + t1;
        m_st[0] = t1 + t2;
        m_ready = (t == 63);
    endtask

    function automatic logic [255:0] model_state();
        return {m_st[0], m_st[1], m_st[2], m_st[3], m_st[4], m_st[5], m_st[6], m_st[7]};
    endfunction

    function automatic logic [255:0] dut_state();
        logic [31:0] a;
        a = state_out[287:256] + state_out[255:224];
        return {a, state_out[223:0]};
    endfunction

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_round(input int t, input logic [31:0] w, input logic [255:0] h);
        round   = 6'(t);
        word_in = w;
        hash_in = h;
        @(posedge clk);
        model_step(t, w, h);
        #1;
        check($sformatf("state_t%0d", t), 288'(dut_state()), 288'(model_state()));
        check($sformatf("ready_t%0d", t), 288'(ready), 288'(m_ready));
    endtask

    task automatic run_abc(input string tag);
        logic [31:0] w;
        for (int t = 0; t < 64; t++) begin
            if (t == 0) w = 32'h61626380;
            else if (t == 15) w = 32'h00000018;
            else if (t < 16) w = 32'h0;
            else w = $urandom();
            run_round(t, w, IV);
            if (t == 0) begin
                check({tag, "_a_r0"}, 288'(dut_state() >> 224), 288'(32'h5d6aebcd));
                check({tag, "_e_r0"}, 288'(dut_state() >> 96) & 288'(32'hffffffff), 288'(32'hfa2a4622));
            end
            if (t == 62) check({tag, "_ready_r62"}, 288'(ready), 288'(1'b0));
        end
        check({tag, "_final"}, 288'(dut_state()), 288'(ABC_FINAL));
        check({tag, "_ready"}, 288'(ready), 288'(1'b1));
    endtask

    task automatic apply_reset(input string tag, input int cycles);
        rst = 1'b1;
        round = 6'($urandom_range(0, 63));
        word_in = $urandom();
        hash_in = {8{$urandom()}};
        repeat (cycles) @(posedge clk);
        model_reset();
        #1;
        check({tag, "_state"}, state_out, 288'(0));
        check({tag, "_ready"}, 288'(ready), 288'(1'b0));
        rst = 1'b0;
    endtask

    initial begin
        logic [255:0] h;
        int t;
        rst = 1'b1;
        round = '0;
        word_in = '0;
        hash_in = '0;
        model_reset();

        apply_reset("reset", 2);

        run_abc("abc1");

        for (int i = 0; i < 5; i++) begin
            run_round(63, $urandom(), IV);
            check("hold_state", 288'(dut_state()), 288'(ABC_FINAL));
            check("hold_ready", 288'(ready), 288'(1'b1));
        end

        run_abc("abc2");

        for (int i = 0; i < 30; i++) run_round(i, (i == 0) ? 32'h61626380 : 32'h0, IV);
        apply_reset("midreset", 1);
        run_abc("abc3");

        for (int r = 0; r < 3; r++) begin
            h = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            for (int i = 0; i < 64; i++) run_round(i, $urandom(), h);
        end

        // Arbitrary round order: restart, random indices, a forced 63 to exercise the freeze.
        run_round(0, $urandom(), IV);
        for (int i = 0; i < 60; i++) begin
            t = (i == 30) ? 63 : int'($urandom_range(1, 63));
            if (i == 45) t = 0;
            run_round(t, $urandom(), IV);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
